// File: rtl/slink_tx_arb.sv
// Frame-granular round-robin arbiter sharing one SLINK_TX transmit path among N_SRC frame FIFOs.
// Grants whole frames, enforces an inter-frame gap and abandons frames that exceed a watchdog.
module slink_tx_arb #(
   parameter int unsigned N_SRC      = 4,
   parameter int unsigned IFG_CYCLES = 8,
   parameter int unsigned TMO_CYCLES = 4096
) (
   input  logic                  clk_12_5m,
   input  logic                  rst_12_5m,
   input  logic [N_SRC-1:0]      src_req,
   input  logic [18*N_SRC-1:0]   src_data,
   input  logic [N_SRC-1:0]      src_dval,
   output logic [N_SRC-1:0]      src_rdreq,
   output logic [N_SRC-1:0]      src_grant,
   output logic [17:0]           mmtx_mactx_data,
   output logic                  mmtx_mactx_dval,
   input  logic                  mactx_mmtx_rdreq,
   input  logic                  slink_tx_eop,
   output logic                  arb_busy,
   output logic                  arb_timeout,
   output logic [15:0]           arb_frame_cnt
);

   localparam int unsigned W_WORD = 18;
   localparam int unsigned W_IDX  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned W_GAP  = 8;
   localparam int unsigned W_WDOG = 16;
   localparam int unsigned W_CNT  = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_XFER  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [N_SRC-1:0]   grant, grant_nxt;
   logic [W_IDX-1:0]   gidx, gidx_nxt;
   logic [W_IDX-1:0]   last, last_nxt;
   logic [W_GAP-1:0]   gap_cnt, gap_nxt;
   logic [W_WDOG-1:0]  wdog, wdog_nxt;
   logic               tmo, tmo_nxt;
   logic [W_CNT-1:0]   frame_cnt, frame_cnt_nxt;
   logic               busy, busy_nxt;
   logic [W_IDX-1:0]   pick;
   logic [W_IDX-1:0]   cand;
   logic               found;
   logic [1:0]         rst_sync;
   logic               rst_n;

   // Assert asynchronously, release only after two clean clock edges
   always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
      if (!rst_12_5m) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // Round-robin search starting just after the last granted source
   always_comb begin
      pick  = last;
      cand  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         cand = W_IDX'((32'(last) + k) % N_SRC);
         if (!found && src_req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_12_5m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         grant     <= '0;
         gidx      <= '0;
         last      <= W_IDX'(N_SRC - 1);
         gap_cnt   <= '0;
         wdog      <= '0;
         tmo       <= 1'b0;
         frame_cnt <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         gidx      <= gidx_nxt;
         last      <= last_nxt;
         gap_cnt   <= gap_nxt;
         wdog      <= wdog_nxt;
         tmo       <= tmo_nxt;
         frame_cnt <= frame_cnt_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      grant_nxt     = grant;
      gidx_nxt      = gidx;
      last_nxt      = last;
      gap_nxt       = gap_cnt;
      wdog_nxt      = wdog;
      tmo_nxt       = 1'b0;
      frame_cnt_nxt = frame_cnt;

      case (state)
         S_IDLE: begin
            if (|src_req) begin
               grant_nxt = N_SRC'(1) << pick;
               gidx_nxt  = pick;
               state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            last_nxt  = gidx;
            wdog_nxt  = '0;
            state_nxt = S_XFER;
         end
         S_XFER: begin
            // eop takes priority over a watchdog expiry in the same cycle
            if (slink_tx_eop) begin
               frame_cnt_nxt = frame_cnt + W_CNT'(1);
               grant_nxt     = '0;
               gap_nxt       = W_GAP'(IFG_CYCLES);
               state_nxt     = S_GAP;
            end else if (wdog == W_WDOG'(TMO_CYCLES - 1)) begin
               tmo_nxt   = 1'b1;
               grant_nxt = '0;
               gap_nxt   = W_GAP'(IFG_CYCLES);
               state_nxt = S_GAP;
            end else begin
               wdog_nxt = wdog + W_WDOG'(1);
            end
         end
         S_GAP: begin
            gap_nxt = gap_cnt - W_GAP'(1);
            if (gap_cnt <= W_GAP'(1)) begin
               gap_nxt   = '0;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
         end
      endcase

      busy_nxt = (state_nxt == S_GRANT) || (state_nxt == S_XFER);
   end

   // Combinational routing keeps the FIFO read latency intact through the arbiter
   always_comb begin
      src_rdreq       = '0;
      mmtx_mactx_data = '0;
      mmtx_mactx_dval = 1'b0;
      if (state == S_XFER) begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
               src_rdreq[i]    = mactx_mmtx_rdreq;
               mmtx_mactx_data = src_data[i*W_WORD +: W_WORD];
               mmtx_mactx_dval = src_dval[i];
            end
         end
      end
   end

   assign src_grant     = grant;
   assign arb_busy      = busy;
   assign arb_timeout   = tmo;
   assign arb_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_slink_tx_arb.sv
// Self-checking bench for slink_tx_arb: directed sequence with randomized data,
// frame lengths and request patterns, checked against a frame-level reference model.
module tb_slink_tx_arb;

   localparam int unsigned N   = 4;
   localparam int unsigned IFG = 8;
   localparam int unsigned TMO = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      src_req;
   logic [18*N-1:0]   src_data;
   logic [N-1:0]      src_dval;
   logic [N-1:0]      src_rdreq;
   logic [N-1:0]      src_grant;
   logic [17:0]       mmtx_mactx_data;
   logic              mmtx_mactx_dval;
   logic              mactx_mmtx_rdreq;
   logic              slink_tx_eop;
   logic              arb_busy;
   logic              arb_timeout;
   logic [15:0]       arb_frame_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int last_m   = N - 1;
   int cnt_m    = 0;

   always #40 clk = ~clk;

   slink_tx_arb #(
      .N_SRC      (N),
      .IFG_CYCLES (IFG),
      .TMO_CYCLES (TMO)
   ) dut (
      .clk_12_5m        (clk),
      .rst_12_5m        (rst_n),
      .src_req          (src_req),
      .src_data         (src_data),
      .src_dval         (src_dval),
      .src_rdreq        (src_rdreq),
      .src_grant        (src_grant),
      .mmtx_mactx_data  (mmtx_mactx_data),
      .mmtx_mactx_dval  (mmtx_mactx_dval),
      .mactx_mmtx_rdreq (mactx_mmtx_rdreq),
      .slink_tx_eop     (slink_tx_eop),
      .arb_busy         (arb_busy),
      .arb_timeout      (arb_timeout),
      .arb_frame_cnt    (arb_frame_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // First requesting source after 'last', wrapping modulo N
   function automatic int pick(input logic [N-1:0] req, input int last);
      logic [N-1:0] r;
      r = req;
      for (int i = 1; i <= int'(N); i++) begin
         if (r[(last + i) % int'(N)]) return (last + i) % int'(N);
      end
      return -1;
   endfunction

   function automatic logic [31:0] onehot(input int idx);
      return (idx < 0) ? 32'd0 : (32'd1 << idx);
   endfunction

   task automatic drive_random();
      src_data         = {8'($urandom), 32'($urandom), 32'($urandom)};
      src_dval         = N'($urandom);
      mactx_mmtx_rdreq = 1'($urandom);
   endtask

   // Waits for a grant while hammering rdreq/eop, which must be ignored outside a transfer
   task automatic wait_grant(output int waited);
      bit seen;
      seen   = 1'b0;
      waited = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         waited = i;
         if (i == 1) check("timeout_single_pulse", 32'(arb_timeout), 32'd0);
         if (src_grant != '0) begin
            seen = 1'b1;
            break;
         end
         check("iso_rdreq", 32'(src_rdreq), 32'd0);
         check("iso_dval", 32'(mmtx_mactx_dval), 32'd0);
         check("iso_data", 32'(mmtx_mactx_data), 32'd0);
         check("iso_busy", 32'(arb_busy), 32'd0);
         drive_random();
         mactx_mmtx_rdreq = 1'b1;
         slink_tx_eop     = 1'($urandom);
      end
      n_assert++;
      assert (seen) else begin
         n_fail++;
         $error("FAIL grant_wait_expired observed=none expected=grant within 40 cycles");
      end
   endtask

   // Runs XFER cycles until eop at cycle eop_at, or until the watchdog abandons the frame
   task automatic xfer(input int g, input int eop_at);
      int  n;
      bit  tmo_exp;
      tmo_exp = (eop_at > int'(TMO));
      n       = tmo_exp ? int'(TMO) : eop_at;
      for (int k = 1; k <= n; k++) begin
         step();
         drive_random();
         slink_tx_eop = (k == eop_at);
         #1;
         check("xfer_rdreq", 32'(src_rdreq), mactx_mmtx_rdreq ? onehot(g) : 32'd0);
         check("xfer_data", 32'(mmtx_mactx_data), 32'(src_data[g*18 +: 18]));
         check("xfer_dval", 32'(mmtx_mactx_dval), 32'(src_dval[g]));
         check("xfer_busy", 32'(arb_busy), 32'd1);
      end
      step();
      slink_tx_eop = 1'b0;
      if (!tmo_exp) cnt_m = (cnt_m + 1) % 65536;
      check("frame_cnt", 32'(arb_frame_cnt), 32'(cnt_m));
      check("timeout_pulse", 32'(arb_timeout), 32'(tmo_exp));
      check("grant_clear", 32'(src_grant), 32'd0);
      check("gap_busy", 32'(arb_busy), 32'd0);
      mactx_mmtx_rdreq = 1'b1;
      #1;
      check("gap_rdreq", 32'(src_rdreq), 32'd0);
   endtask

   // One full frame: grant check against the model, latency check, transfer
   task automatic do_frame(input int exp_wait, input int eop_at, input bit drop_req);
      int w;
      int ge;
      wait_grant(w);
      ge = pick(src_req, last_m);
      check("grant", 32'(src_grant), onehot(ge));
      check("grant_latency", 32'(w), 32'(exp_wait));
      check("grant_busy", 32'(arb_busy), 32'd1);
      last_m = ge;
      if (drop_req) src_req = '0;
      xfer(ge, eop_at);
   endtask

   initial begin
      int w;
      int ge;
      rst_n            = 1'b0;
      src_req          = '0;
      src_data         = '0;
      src_dval         = '0;
      mactx_mmtx_rdreq = 1'b0;
      slink_tx_eop     = 1'b0;
      repeat (3) step();

      check("rst_grant", 32'(src_grant), 32'd0);
      check("rst_rdreq", 32'(src_rdreq), 32'd0);
      check("rst_busy", 32'(arb_busy), 32'd0);
      check("rst_timeout", 32'(arb_timeout), 32'd0);
      check("rst_frame_cnt", 32'(arb_frame_cnt), 32'd0);
      check("rst_dval", 32'(mmtx_mactx_dval), 32'd0);
      check("rst_data", 32'(mmtx_mactx_data), 32'd0);

      rst_n = 1'b1;
      repeat (4) step();

      // Idle isolation: rdreq, dval and a stray eop must have no effect
      mactx_mmtx_rdreq = 1'b1;
      src_dval         = '1;
      slink_tx_eop     = 1'b1;
      repeat (3) begin
         step();
         check("idle_rdreq", 32'(src_rdreq), 32'd0);
         check("idle_dval", 32'(mmtx_mactx_dval), 32'd0);
         check("idle_frame_cnt", 32'(arb_frame_cnt), 32'd0);
         check("idle_busy", 32'(arb_busy), 32'd0);
      end
      slink_tx_eop = 1'b0;

      // Single source 2, request dropped mid-frame, eop on the 7th transfer cycle
      src_req = 4'b0100;
      do_frame(1, 7, 1'b1);

      // All sources continuously: strict rotation, full gap between frames
      src_req = 4'b1111;
      for (int f = 0; f < 8; f++) begin
         do_frame(int'(IFG) + 1, int'($urandom_range(1, 10)), 1'b0);
      end
      check("fair_frame_cnt", 32'(arb_frame_cnt), 32'd9);

      // Watchdog: no eop ever, then eop coinciding with expiry
      do_frame(int'(IFG) + 1, 1000, 1'b0);
      do_frame(int'(IFG) + 1, int'(TMO), 1'b0);

      // Random request patterns and frame lengths, some exceeding the watchdog
      for (int f = 0; f < 12; f++) begin
         src_req = N'($urandom_range(1, 15));
         do_frame(int'(IFG) + 1, int'($urandom_range(1, 20)), 1'($urandom));
      end

      // Reset asserted at the third transfer word
      src_req = 4'b1111;
      wait_grant(w);
      ge = pick(src_req, last_m);
      check("pre_rst_grant", 32'(src_grant), onehot(ge));
      repeat (3) step();
      mactx_mmtx_rdreq = 1'b1;
      src_dval         = '1;
      #1;
      check("pre_rst_rdreq", 32'(src_rdreq), onehot(ge));
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant", 32'(src_grant), 32'd0);
      check("mid_rst_rdreq", 32'(src_rdreq), 32'd0);
      check("mid_rst_dval", 32'(mmtx_mactx_dval), 32'd0);
      check("mid_rst_busy", 32'(arb_busy), 32'd0);
      check("mid_rst_frame_cnt", 32'(arb_frame_cnt), 32'd0);
      repeat (2) step();
      rst_n  = 1'b1;
      last_m = N - 1;
      cnt_m  = 0;
      wait_grant(w);
      check("post_rst_grant", 32'(src_grant), onehot(pick(src_req, last_m)));
      check("post_rst_frame_cnt", 32'(arb_frame_cnt), 32'd0);
      last_m = 0;
      xfer(0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/slink_tx_arb.md
Name: slink_tx_arb

Overview:
- Frame-granular round-robin arbiter that shares one SLINK_TX serial transmit path among N frame sources. Each source is a frame FIFO.
- Sits between the per-source frame FIFOs and SLINK_TX's mmtx_mactx_* interface.
- Routes the read request and data of the granted source only.
- Enforces an inter-frame gap and a watchdog timeout. Runs entirely in the 12.5 MHz domain.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- IFG_CYCLES, 8, idle cycles held between frames (1..255).
- TMO_CYCLES, 4096, maximum XFER cycles before the frame is abandoned (up to 2^16-1).

Ports:
- clk_12_5m  in  1  system clock, 12.5 MHz.
- rst_12_5m  in  1  reset; asynchronous, active-low.
- src_req  in  N_SRC  per source: a complete frame is queued.
- src_data  in  18*N_SRC  per-source FIFO read data; source i occupies bits [18i+17:18i].
- src_dval  in  N_SRC  per-source FIFO read data valid.
- src_rdreq  out  N_SRC  per-source FIFO read request.
- src_grant  out  N_SRC  one-hot grant; all zero when no source is granted.
- mmtx_mactx_data  out  18  to SLINK_TX.
- mmtx_mactx_dval  out  1  to SLINK_TX.
- mactx_mmtx_rdreq  in  1  read request from SLINK_TX.
- slink_tx_eop  in  1  one-cycle end-of-frame pulse from SLINK_TX.
- arb_busy  out  1  high in GRANT and XFER.
- arb_timeout  out  1  one-cycle pulse when the watchdog fires.
- arb_frame_cnt  out  16  count of completed frames; wraps.

Behaviour:
- Reset (rst_12_5m low, asynchronous):
  - state = IDLE.
  - src_grant = 0, src_rdreq = 0, arb_busy = 0, arb_timeout = 0, arb_frame_cnt = 0, gap and watchdog counters = 0.
  - Round-robin pointer last = N_SRC-1, so source 0 has first priority.
  - Reset is released synchronously inside the block: two-flop synchroniser on deassertion.
- FSM states: IDLE, GRANT, XFER, GAP.
- IDLE:
  - If any src_req bit is high, select the first requesting index searching last+1, last+2, ... with modulo N_SRC wrap.
  - Register the one-hot src_grant and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: one settle cycle. Set last = granted index, clear the watchdog, go to XFER.
  - Latency: src_req sampled high at edge t → src_grant valid after t; XFER entered at t+2.
- XFER routing (combinational, so FIFO read latency is preserved end to end):
  - src_rdreq[g] = mactx_mmtx_rdreq; all other src_rdreq bits = 0.
  - mmtx_mactx_data = src_data of source g.
  - mmtx_mactx_dval = src_dval[g].
- XFER exit conditions:
  - slink_tx_eop high: increment arb_frame_cnt (wraps 0xFFFF→0), clear src_grant, load the gap counter with IFG_CYCLES, go to GAP.
  - Watchdog reaches TMO_CYCLES-1 without eop: pulse arb_timeout for 1 cycle, clear src_grant, force src_rdreq to 0, load the gap counter, go to GAP. arb_frame_cnt is not incremented.
  - eop and watchdog expiry in the same cycle: eop wins, no timeout pulse.
- Outside XFER:
  - src_rdreq = 0 and mmtx_mactx_dval = 0.
  - mmtx_mactx_data is held at 0.
  - mactx_mmtx_rdreq is ignored.
- GAP: decrement the gap counter each cycle; when it is 0, go to IDLE. New arbitration is therefore earliest IFG_CYCLES+1 cycles after eop.
- Request changes:
  - A src_req deassertion during GRANT or XFER has no effect; the frame completes.
  - A src_req change in GAP is evaluated only in IDLE.
  - slink_tx_eop in IDLE, GRANT or GAP is ignored and not counted.
- Fairness: with all sources requesting continuously, grants cycle 0,1,2,...,N_SRC-1,0. No source waits more than N_SRC-1 frames.
- Mid-frame reset: all outputs go to reset values immediately. The FIFO partial frame is not the arbiter's concern.

Test Plan:
- Single source: src_req=4'b0100, frame of 6 words, eop at 7th XFER cycle → src_grant=4'b0100 at t+1; 6 rdreq forwarded only to source 2; arb_frame_cnt=1; IDLE after 8 GAP cycles.
- All four requesting continuously for 8 frames → grant order 0,1,2,3,0,1,2,3; gap ≥ IFG_CYCLES+1 cycles between eop and next grant; arb_frame_cnt=8.
- Watchdog: TMO_CYCLES=16, granted source never produces eop → arb_timeout pulses exactly once, 16 cycles after XFER entry; arb_frame_cnt unchanged; src_rdreq=0 from then on; next requester granted after the gap.
- eop and watchdog expiry in the same cycle → no arb_timeout pulse; arb_frame_cnt increments.
- Isolation: mactx_mmtx_rdreq held high during IDLE and GAP → src_rdreq stays 0 and mmtx_mactx_dval stays 0; a stray eop in IDLE leaves the count unchanged.
- Reset asserted mid-XFER at word 3 → src_grant and src_rdreq go to 0 asynchronously; after release, first grant goes to source 0; arb_frame_cnt=0.
